test_cam: RTL and testbench

Top-level OV7670-style camera-to-VGA bridge. It captures 320x240 RGB565 frames from the camera's parallel byte bus, stores them as RGB332 in an on-chip frame buffer, and displays the buffer at the top-left of a 640x480@60 Hz VGA raster with 4-bit-per-channel outputs. It also drives the camera clock and control pins.

---
 rtl/test_cam_pkg.sv | 29 ++
 rtl/test_cam_capture.sv | 116 +++++++++++
 rtl/test_cam.sv | 137 +++++++++++++
 tb/tb_test_cam.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/test_cam_pkg.sv
// Shared constants and helpers for the OV7670-to-VGA bridge.
// Holds the VGA 640x480@60 timing, the 320x240 capture geometry and the RGB565-to-RGB332 packing.
package test_cam_pkg;

  localparam int CAM_W    = 320;
  localparam int CAM_H    = 240;
  localparam int FB_AW    = 17;
  localparam int XCLK_DIV = 4;

  localparam int H_VIS  = 640;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;
  localparam int V_VIS  = 480;
  localparam int V_FP   = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 33;

  typedef enum logic {
    WAIT_FRAME = 1'b0,
    CAPTURE    = 1'b1
  } cap_state_t;

  // byte1 = R[4:0],G[5:3]; byte2 = G[2:0],B[4:0]; keep the top bits of each channel.
  function automatic logic [7:0] pack_rgb332(input logic [7:0] byte1, input logic [7:0] byte2);
    return {byte1[7:5], byte1[2:0], byte2[4:3]};
  endfunction

endpackage

// File: rtl/test_cam_capture.sv
// Camera capture: synchronizes the OV7670 bus to clk, pairs RGB565 bytes and emits RGB332 buffer writes.
// Starts on a vsync falling edge when capture is enabled; ends on vsync rising or a full buffer.
module cam_capture #(
  parameter int FB_DEPTH = test_cam_pkg::CAM_W * test_cam_pkg::CAM_H
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            pclk,
  input  logic                            vsync,
  input  logic                            href,
  input  logic [7:0]                      px_data,
  input  logic                            btn,
  output logic                            wr_en,
  output logic [test_cam_pkg::FB_AW-1:0]  wr_addr,
  output logic [7:0]                      wr_dat
);
  import test_cam_pkg::*;

  localparam logic [FB_AW-1:0] DEPTH_A = FB_AW'(FB_DEPTH);

  logic [1:0] pclk_sy, vsync_sy, href_sy, btn_sy;
  logic [7:0] data_sy1, data_sy2;
  logic       pclk_prev, vsync_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pclk_sy    <= '0;
      vsync_sy   <= '0;
      href_sy    <= '0;
      btn_sy     <= '0;
      data_sy1   <= '0;
      data_sy2   <= '0;
      pclk_prev  <= 1'b0;
      vsync_prev <= 1'b0;
    end else begin
      pclk_sy    <= {pclk_sy[0], pclk};
      vsync_sy   <= {vsync_sy[0], vsync};
      href_sy    <= {href_sy[0], href};
      btn_sy     <= {btn_sy[0], btn};
      data_sy1   <= px_data;
      data_sy2   <= data_sy1;
      pclk_prev  <= pclk_sy[1];
      vsync_prev <= vsync_sy[1];
    end
  end

  logic pclk_rise, vsync_rise, vsync_fall;
  assign pclk_rise  = pclk_sy[1] & ~pclk_prev;
  assign vsync_rise = vsync_sy[1] & ~vsync_prev;
  assign vsync_fall = ~vsync_sy[1] & vsync_prev;

  cap_state_t       state, state_nx;
  logic [FB_AW-1:0] addr, addr_nx, wr_addr_nx;
  logic             phase, phase_nx, wr_en_nx;
  logic [7:0]       byte1, byte1_nx, wr_dat_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= WAIT_FRAME;
      addr    <= '0;
      phase   <= 1'b0;
      byte1   <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_dat  <= '0;
    end else begin
      state   <= state_nx;
      addr    <= addr_nx;
      phase   <= phase_nx;
      byte1   <= byte1_nx;
      wr_en   <= wr_en_nx;
      wr_addr <= wr_addr_nx;
      wr_dat  <= wr_dat_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    addr_nx    = addr;
    phase_nx   = phase;
    byte1_nx   = byte1;
    wr_en_nx   = 1'b0;
    wr_addr_nx = wr_addr;
    wr_dat_nx  = wr_dat;
    case (state)
      WAIT_FRAME: begin
        if (vsync_fall && btn_sy[1]) begin
          state_nx = CAPTURE;
          addr_nx  = '0;
          phase_nx = 1'b0;
        end
      end
      CAPTURE: begin
        // A full buffer ends the frame so the address can never wrap onto pixel 0.
        if (vsync_rise || addr == DEPTH_A) begin
          state_nx = WAIT_FRAME;
        end else if (!href_sy[1]) begin
          phase_nx = 1'b0;
        end else if (pclk_rise) begin
          if (!phase) begin
            byte1_nx = data_sy2;
            phase_nx = 1'b1;
          end else begin
            wr_en_nx   = 1'b1;
            wr_addr_nx = addr;
            wr_dat_nx  = pack_rgb332(byte1, data_sy2);
            addr_nx    = addr + FB_AW'(1);
            phase_nx   = 1'b0;
          end
        end
      end
      default: state_nx = WAIT_FRAME;
    endcase
  end

endmodule

// File: rtl/test_cam.sv
// Camera-to-VGA bridge: RGB332 frame buffer written by cam_capture, scanned out top-left on a VGA raster.
// Colour and sync outputs trail the h/v counters by 2 clk (RAM read + output register).
module test_cam #(
  parameter int CAM_W  = test_cam_pkg::CAM_W,
  parameter int CAM_H  = test_cam_pkg::CAM_H,
  parameter int H_VIS  = test_cam_pkg::H_VIS,
  parameter int H_FP   = test_cam_pkg::H_FP,
  parameter int H_SYNC = test_cam_pkg::H_SYNC,
  parameter int H_BP   = test_cam_pkg::H_BP,
  parameter int V_VIS  = test_cam_pkg::V_VIS,
  parameter int V_FP   = test_cam_pkg::V_FP,
  parameter int V_SYNC = test_cam_pkg::V_SYNC,
  parameter int V_BP   = test_cam_pkg::V_BP
) (
  input  logic       clk,
  input  logic       rst,
  output logic       VGA_Hsync_n,
  output logic       VGA_Vsync_n,
  output logic [3:0] VGA_R,
  output logic [3:0] VGA_G,
  output logic [3:0] VGA_B,
  output logic       CAM_xclk,
  output logic       CAM_pwdn,
  output logic       CAM_reset,
  input  logic       CAM_pclk,
  input  logic       CAM_vsync,
  input  logic       CAM_href,
  input  logic [7:0] CAM_px_data,
  input  logic       CBtn
);
  import test_cam_pkg::*;

  localparam int FB_DEPTH = CAM_W * CAM_H;
  localparam int MEM_AW   = $clog2(FB_DEPTH);
  localparam logic [9:0] H_END  = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_END  = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] HS_BEG = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END = 10'(V_VIS + V_FP + V_SYNC);
  localparam logic [9:0] IMG_W  = 10'(CAM_W);
  localparam logic [9:0] IMG_H  = 10'(CAM_H);
  localparam logic [FB_AW-1:0] ROW_STEP = FB_AW'(CAM_W);

  assign CAM_pwdn  = 1'b0;
  assign CAM_reset = 1'b1;

  logic             wr_en;
  logic [FB_AW-1:0] wr_addr;
  logic [7:0]       wr_dat;

  cam_capture #(.FB_DEPTH(FB_DEPTH)) u_capture (
    .clk     (clk),
    .rst     (rst),
    .pclk    (CAM_pclk),
    .vsync   (CAM_vsync),
    .href    (CAM_href),
    .px_data (CAM_px_data),
    .btn     (CBtn),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_dat  (wr_dat)
  );

  logic [1:0]       div_cnt;
  logic             pix_en;
  logic [9:0]       h, v;
  logic [FB_AW-1:0] row_base;

  assign pix_en = (div_cnt == 2'(XCLK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt  <= '0;
      CAM_xclk <= 1'b0;
      h        <= '0;
      v        <= '0;
      row_base <= '0;
    end else begin
      div_cnt  <= div_cnt + 2'd1;
      CAM_xclk <= div_cnt[1];
      if (pix_en) begin
        if (h == H_END) begin
          h <= '0;
          if (v == V_END) begin
            v        <= '0;
            row_base <= '0;
          end else begin
            v <= v + 10'd1;
            if (v < IMG_H) row_base <= row_base + ROW_STEP;
          end
        end else begin
          h <= h + 10'd1;
        end
      end
    end
  end

  logic             active;
  logic [FB_AW-1:0] rd_addr;
  logic [7:0]       rd_dat;
  logic [7:0]       fb_mem [FB_DEPTH];

  assign active  = (h < IMG_W) && (v < IMG_H);
  assign rd_addr = active ? row_base + FB_AW'(h) : '0;

  // Read-before-write: a same-address read returns the old byte.
  always_ff @(posedge clk) begin
    if (wr_en) fb_mem[wr_addr[MEM_AW-1:0]] <= wr_dat;
    rd_dat <= fb_mem[rd_addr[MEM_AW-1:0]];
  end

  logic active_d, hs_d, vs_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_d    <= 1'b0;
      hs_d        <= 1'b1;
      vs_d        <= 1'b1;
      VGA_Hsync_n <= 1'b1;
      VGA_Vsync_n <= 1'b1;
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
    end else begin
      active_d    <= active;
      hs_d        <= !(h >= HS_BEG && h < HS_END);
      vs_d        <= !(v >= VS_BEG && v < VS_END);
      VGA_Hsync_n <= hs_d;
      VGA_Vsync_n <= vs_d;
      VGA_R       <= active_d ? {rd_dat[7:5], 1'b0}  : 4'd0;
      VGA_G       <= active_d ? {rd_dat[4:2], 1'b0}  : 4'd0;
      VGA_B       <= active_d ? {rd_dat[1:0], 2'b00} : 4'd0;
    end
  end

endmodule

// File: tb/tb_test_cam.sv
// Directed bench for test_cam on a shrunken raster (8x6 image, 24x15 VGA frame) so whole frames fit the run.
module tb_test_cam;
  localparam int CW = 8, CH = 6;
  localparam int HV = 16, HFP = 2, HS = 4, HBP = 2, HT = 24;
  localparam int VV = 10, VFP = 1, VS = 2, VBP = 2, VT = 15;
  localparam int LIMIT = 5000;
  localparam logic [11:0] RED = 12'hE00, GRN = 12'h0E0, BLU = 12'h00C, WHT = 12'hEEC;

  logic clk = 1'b0, rst = 1'b1;
  logic hs_n, vs_n, xclk, pwdn, creset;
  logic [3:0] vr, vg, vb;
  logic pclk = 1'b0, cvs = 1'b1, href = 1'b0, btn = 1'b0;
  logic [7:0] pxd = 8'h00;

  int n_cmp = 0, n_bad = 0;
  int outside_nz;
  logic [11:0] scr [VV][HV];

  always #5 clk = ~clk;

  test_cam #(
    .CAM_W(CW), .CAM_H(CH), .H_VIS(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_VIS(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
  ) dut (
    .clk(clk), .rst(rst), .VGA_Hsync_n(hs_n), .VGA_Vsync_n(vs_n),
    .VGA_R(vr), .VGA_G(vg), .VGA_B(vb), .CAM_xclk(xclk), .CAM_pwdn(pwdn),
    .CAM_reset(creset), .CAM_pclk(pclk), .CAM_vsync(cvs), .CAM_href(href),
    .CAM_px_data(pxd), .CBtn(btn)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] pair_of(input int pat, input int idx);
    logic [15:0] rot [4];
    rot[0] = 16'hF800; rot[1] = 16'h07E0; rot[2] = 16'h001F; rot[3] = 16'hFFFF;
    case (pat)
      0: return rot[idx % 4];
      1: return 16'hF800;
      2: return 16'h07E0;
      default: return 16'h001F;
    endcase
  endfunction

  // One camera byte per 4 clk; data changes with pclk low and is sampled on the rising edge.
  task automatic cam_byte(input logic hr, input logic [7:0] d);
    pclk = 1'b0; href = hr; pxd = d;
    repeat (2) @(negedge clk);
    pclk = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic cam_frame(input int pat, input int lines, input int pat_extra, input bit stray);
    logic [15:0] pr;
    cvs = 1'b1;
    repeat (4) cam_byte(1'b0, 8'h00);
    cvs = 1'b0;
    repeat (2) cam_byte(1'b0, 8'h00);
    for (int y = 0; y < lines; y++) begin
      if (stray && (y == 0 || y == 3)) begin
        cam_byte(1'b1, 8'hF8);
        cam_byte(1'b0, 8'h00);
      end
      for (int x = 0; x < CW; x++) begin
        pr = pair_of((y < CH) ? pat : pat_extra, y * CW + x);
        cam_byte(1'b1, pr[15:8]);
        cam_byte(1'b1, pr[7:0]);
      end
      repeat (2) cam_byte(1'b0, 8'h00);
    end
    cvs = 1'b1;
    repeat (2) cam_byte(1'b0, 8'h00);
  endtask

  // Leaves the caller on the first negedge where the chosen sync is low.
  task automatic wait_fall(input bit use_v, output bit ok);
    int t = 0;
    while (((use_v ? vs_n : hs_n) !== 1'b1) && t < LIMIT) begin @(negedge clk); t++; end
    while (((use_v ? vs_n : hs_n) !== 1'b0) && t < LIMIT) begin @(negedge clk); t++; end
    ok = (t < LIMIT);
  endtask

  task automatic measure(input bit use_v, input string tag, input int exp_low, input int exp_per);
    bit ok;
    int cnt = 0;
    wait_fall(use_v, ok);
    check({tag, "_seen"}, 32'(ok), 32'd1);
    while (((use_v ? vs_n : hs_n) === 1'b0) && cnt < LIMIT) begin @(negedge clk); cnt++; end
    check({tag, "_low"}, 32'(cnt), 32'(exp_low));
    while (((use_v ? vs_n : hs_n) === 1'b1) && cnt < LIMIT) begin @(negedge clk); cnt++; end
    check({tag, "_period"}, 32'(cnt), 32'(exp_per));
  endtask

  // Samples each pixel mid-window from vsync start through the last visible line.
  task automatic grab(input string tag);
    bit ok;
    int line, x;
    logic [11:0] px;
    outside_nz = 0;
    wait_fall(1'b1, ok);
    check({tag, "_vsync"}, 32'(ok), 32'd1);
    @(negedge clk);
    for (int p = 0; p < (VS + VBP + VV) * HT; p++) begin
      line = p / HT - (VS + VBP);
      x    = p % HT;
      px   = {vr, vg, vb};
      if (line >= 0 && x < HV) scr[line][x] = px;
      if (!(line >= 0 && line < CH && x < CW) && px != 12'h000) outside_nz++;
      repeat (4) @(negedge clk);
    end
    check({tag, "_blank_zero"}, 32'(outside_nz), 32'd0);
  endtask

  initial begin
    int edges;
    logic xprev;
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check("rst_hsync", 32'(hs_n), 32'd1);
    check("rst_vsync", 32'(vs_n), 32'd1);
    check("rst_rgb", 32'({vr, vg, vb}), 32'd0);
    check("rst_xclk", 32'(xclk), 32'd0);
    check("pwdn", 32'(pwdn), 32'd0);
    check("cam_reset", 32'(creset), 32'd1);
    rst = 1'b0;

    edges = 0; xprev = xclk;
    repeat (40) begin
      @(negedge clk);
      if (xclk && !xprev) edges++;
      xprev = xclk;
    end
    check("xclk_edges", 32'(edges), 32'd10);

    measure(1'b0, "hsync", HS * 4, HT * 4);
    measure(1'b1, "vsync", VS * HT * 4, VT * HT * 4);
    measure(1'b0, "hsync2", HS * 4, HT * 4);

    btn = 1'b1;
    cam_frame(0, CH, 0, 1'b0);
    grab("colour");
    check("px0_red", 32'(scr[0][0]), 32'(RED));
    check("px1_green", 32'(scr[0][1]), 32'(GRN));
    check("px2_blue", 32'(scr[0][2]), 32'(BLU));
    check("px3_white", 32'(scr[0][3]), 32'(WHT));
    check("px4_red", 32'(scr[0][4]), 32'(RED));
    check("row1_px0_red", 32'(scr[1][0]), 32'(RED));
    check("last_px_white", 32'(scr[CH-1][CW-1]), 32'(WHT));

    cam_frame(2, CH, 2, 1'b1);
    grab("stray");
    check("stray_r0p0", 32'(scr[0][0]), 32'(GRN));
    check("stray_r0p1", 32'(scr[0][1]), 32'(GRN));
    check("stray_r3p0", 32'(scr[3][0]), 32'(GRN));
    check("stray_last", 32'(scr[CH-1][CW-1]), 32'(GRN));

    cam_frame(1, CH, 1, 1'b0);
    grab("red");
    check("red_p0", 32'(scr[0][0]), 32'(RED));
    btn = 1'b0;
    cam_frame(3, CH, 3, 1'b0);
    grab("frozen");
    check("frozen_p0", 32'(scr[0][0]), 32'(RED));
    check("frozen_r3p5", 32'(scr[3][5]), 32'(RED));
    btn = 1'b1;
    cam_frame(3, CH, 3, 1'b0);
    grab("live");
    check("live_p0", 32'(scr[0][0]), 32'(BLU));
    check("live_last", 32'(scr[CH-1][CW-1]), 32'(BLU));

    cam_frame(2, CH + 4, 1, 1'b0);
    grab("overlong");
    check("over_p0", 32'(scr[0][0]), 32'(GRN));
    check("over_p1", 32'(scr[0][1]), 32'(GRN));
    check("over_last", 32'(scr[CH-1][CW-1]), 32'(GRN));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
